// File: rtl/pio_irq_bank.sv
// Avalon-MM PIO: synchronised/debounced input bank with edge capture and masked IRQ,
// plus an output bank with atomic set/clear. Define DEBOUNCE_EN for per-bit debounce counters.
module pio_irq_bank #(
    parameter int unsigned IN_WIDTH   = 2,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned EDGE_TYPE  = 1,
    parameter int unsigned DEB_CYCLES = 50000,
    parameter logic [31:0] OUT_RESET  = 32'd0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_chipselect,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  pio_in_export,
    output logic [OUT_WIDTH-1:0] pio_out_export
);

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

    logic                 wr_en;
    logic                 rd_en;
    logic [IN_WIDTH-1:0]  sync1;
    logic [IN_WIDTH-1:0]  sync2;
    logic [IN_WIDTH-1:0]  stable;
    logic [IN_WIDTH-1:0]  stable_d;
    logic [IN_WIDTH-1:0]  edge_det;
    logic [IN_WIDTH-1:0]  edge_clr;
    logic [IN_WIDTH-1:0]  edge_cap;
    logic [IN_WIDTH-1:0]  mask;
    logic [OUT_WIDTH-1:0] out_reg;
    logic [31:0]          rd_mux;
    logic                 unused_wdata;

    assign wr_en          = avs_chipselect & avs_write;
    assign rd_en          = avs_chipselect & avs_read;
    assign pio_out_export = out_reg;
    assign unused_wdata   = ^avs_writedata;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pio_in_export;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] deb_cnt [IN_WIDTH];

    // A bit only moves once sync2 has disagreed with it for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk_clk) begin
        for (int i = 0; i < int'(IN_WIDTH); i++) begin
            if (!reset_reset_n) begin
                deb_cnt[i] <= '0;
                stable[i]  <= 1'b0;
            end else if (sync2[i] == stable[i]) begin
                deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == CNT_TC) begin
                deb_cnt[i] <= '0;
                stable[i]  <= sync2[i];
            end else begin
                deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) stable <= '0;
        else                stable <= sync2;
    end
`endif

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0)      edge_det = stable & ~stable_d;
        else if (EDGE_TYPE == 1) edge_det = ~stable & stable_d;
        else                     edge_det = stable ^ stable_d;
    end

    always_comb begin
        edge_clr = '0;
        if (wr_en && avs_address == ADDR_EDGE_CAP)
            edge_clr = avs_writedata[IN_WIDTH-1:0];
    end

    // A fresh edge wins over a simultaneous write-one-to-clear.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            stable_d <= '0;
            edge_cap <= '0;
            mask     <= '0;
            irq      <= 1'b0;
        end else begin
            stable_d <= stable;
            edge_cap <= (edge_cap & ~edge_clr) | edge_det;
            if (wr_en && avs_address == ADDR_IRQ_MASK)
                mask <= avs_writedata[IN_WIDTH-1:0];
            irq <= |(edge_cap & mask);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            out_reg <= OUT_RESET[OUT_WIDTH-1:0];
        end else if (wr_en) begin
            case (avs_address)
                ADDR_DATA_OUT: out_reg <= avs_writedata[OUT_WIDTH-1:0];
                ADDR_OUT_SET:  out_reg <= out_reg | avs_writedata[OUT_WIDTH-1:0];
                ADDR_OUT_CLR:  out_reg <= out_reg & ~avs_writedata[OUT_WIDTH-1:0];
                default:       out_reg <= out_reg;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_DATA_IN:  rd_mux[IN_WIDTH-1:0]  = stable;
            ADDR_DATA_OUT: rd_mux[OUT_WIDTH-1:0] = out_reg;
            ADDR_IRQ_MASK: rd_mux[IN_WIDTH-1:0]  = mask;
            ADDR_EDGE_CAP: rd_mux[IN_WIDTH-1:0]  = edge_cap;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) avs_readdata <= '0;
        else if (rd_en)     avs_readdata <= rd_mux;
    end

endmodule

// File: tb/tb_pio_irq_bank.sv
// Directed bench for pio_irq_bank (IN_WIDTH=2, OUT_WIDTH=16, falling edges, DEB_CYCLES=8).
// Timing expectations follow whichever debounce build is compiled.
module tb_pio_irq_bank;

    localparam int DEB = 8;
`ifdef DEBOUNCE_EN
    localparam int LAT = 2 + DEB;
    localparam logic [31:0] T4_CAP = 32'h0;
`else
    localparam int LAT = 3;
    localparam logic [31:0] T4_CAP = 32'h2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  addr;
    logic        cs, rd, wr;
    logic [31:0] wdata;
    logic [31:0] readdata;
    logic        irq;
    logic [1:0]  pin;
    logic [15:0] pout;
    logic [31:0] r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pio_irq_bank #(
        .IN_WIDTH(2), .OUT_WIDTH(16), .EDGE_TYPE(1), .DEB_CYCLES(DEB), .OUT_RESET(32'd0)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .avs_address(addr), .avs_chipselect(cs), .avs_read(rd), .avs_write(wr),
        .avs_writedata(wdata), .avs_readdata(readdata), .irq(irq),
        .pio_in_export(pin), .pio_out_export(pout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; cs = 1'b1; wr = 1'b1;
        tick(1);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        addr = a; cs = 1'b1; rd = 1'b1;
        tick(1);
        cs = 1'b0; rd = 1'b0;
        d = readdata;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; cs = 1'b0; rd = 1'b0; wr = 1'b0; wdata = '0; pin = 2'b11;
        tick(2);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        check("rst_out", {16'd0, pout}, 32'd0);
        rst_n = 1'b1;

        // reset values through the bus
        bus_rd(3'd1, r); check("t1_data_out", r, 32'h0);
        bus_rd(3'd2, r); check("t1_mask", r, 32'h0);
        bus_rd(3'd3, r); check("t1_edge_cap", r, 32'h0);
        check("t1_irq", {31'd0, irq}, 32'd0);
        tick(LAT + 4);
        bus_rd(3'd0, r); check("settle_data_in", r, 32'h3);
        bus_rd(3'd3, r); check("settle_no_rise_cap", r, 32'h0);

        // output bank and register map corners
        bus_wr(3'd1, 32'h0000_00F0);
        bus_wr(3'd4, 32'h0000_0003);
        bus_wr(3'd5, 32'h0000_0010);
        check("t2_out_export", {16'd0, pout}, 32'h0000_00E3);
        bus_rd(3'd1, r); check("t2_readback", r, 32'h0000_00E3);
        tick(3);
        check("t2_readdata_held", readdata, 32'h0000_00E3);
        bus_wr(3'd4, 32'hFFFF_0000);
        check("set_upper_ignored", {16'd0, pout}, 32'h0000_00E3);
        bus_wr(3'd0, 32'h0);
        bus_wr(3'd6, 32'hFFFF_FFFF);
        bus_rd(3'd0, r); check("ro_write_ignored", r, 32'h3);
        bus_rd(3'd1, r); check("addr6_write_ignored", r, 32'h0000_00E3);
        bus_rd(3'd4, r); check("wo_read_zero", r, 32'h0);
        bus_rd(3'd7, r); check("addr7_read_zero", r, 32'h0);
        bus_wr(3'd2, 32'hFFFF_FFFF);
        bus_rd(3'd2, r); check("mask_width", r, 32'h3);
        bus_wr(3'd2, 32'h1);

        // falling edge on bit0: capture and irq timing
        pin = 2'b10;
        tick(LAT + 1);
        check("t3_irq_before", {31'd0, irq}, 32'd0);
        tick(1);
        check("t3_irq_set", {31'd0, irq}, 32'd1);
        bus_rd(3'd3, r); check("t3_edge_cap", r, 32'h1);
        bus_rd(3'd0, r); check("t3_data_in", r, 32'h2);
        bus_wr(3'd3, 32'h1);
        check("t3_irq_w1c_same", {31'd0, irq}, 32'd1);
        tick(1);
        check("t3_irq_w1c_clr", {31'd0, irq}, 32'd0);
        bus_rd(3'd3, r); check("t3_cap_cleared", r, 32'h0);

        // 5-cycle low glitch on bit1
        pin = 2'b00;
        tick(5);
        pin = 2'b10;
        tick(LAT + 6);
        bus_rd(3'd0, r); check("t4_data_in", r, 32'h2);
        bus_rd(3'd3, r); check("t4_edge_cap", r, T4_CAP);
        check("t4_irq", {31'd0, irq}, 32'd0);
        bus_wr(3'd3, 32'h3);

        // W1C racing a new capture on bit0
        pin = 2'b11; tick(LAT + 4);
        pin = 2'b10; tick(LAT + 4);
        check("t5_irq_first", {31'd0, irq}, 32'd1);
        pin = 2'b11; tick(LAT + 4);
        check("t5_irq_hold", {31'd0, irq}, 32'd1);
        pin = 2'b10;
        tick(LAT);
        bus_wr(3'd3, 32'h1);
        tick(1);
        check("t5_irq_set_wins", {31'd0, irq}, 32'd1);
        bus_rd(3'd3, r); check("t5_cap_set_wins", r, 32'h1);
        bus_wr(3'd2, 32'h0);
        check("mask_clr_irq_same", {31'd0, irq}, 32'd1);
        tick(1);
        check("mask_clr_irq_next", {31'd0, irq}, 32'd0);

        // reset in the middle of a debounce count
        pin = 2'b00; tick(LAT + 4);
        pin = 2'b11;
        tick(7);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("t6_rst_irq", {31'd0, irq}, 32'd0);
        check("t6_rst_out", {16'd0, pout}, 32'd0);
        tick(LAT - 1);
        bus_rd(3'd0, r); check("t6_not_yet", r, 32'h0);
        bus_rd(3'd0, r); check("t6_changed", r, 32'h3);
        bus_rd(3'd2, r); check("t6_mask_reset", r, 32'h0);
        bus_rd(3'd3, r); check("t6_cap_reset", r, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
